fm_sb_freeze_seq: RTL and testbench
===================================

Name: fm_sb_freeze_seq

Overview:
- Parametrised spy-buffer freeze/playback controller for the FM block; next generation of the per-buffer freeze/playback mask decoder.
- Adds an arm/trigger/post-trigger-delay freeze sequencer, parametric channel count with generic mask word indexing, staged playback-mode updates and status counters.
- Sits between the FM AXI control registers and the N_SB spy buffers; drives one freeze bit and one playback-mode field per buffer.

Parameters:
- N_SB, 32, number of spy buffers controlled (1..256).
- PB_MODE_W, 2, width of one playback-mode field.
- DLY_W, 16, width of the post-trigger delay.
- CNT_W, 16, width of the trigger counter.

Ports:
- axi_clk  in  1  control clock.
- axi_rst_n  in  1  asynchronous active-low reset.
- global_freeze  in  1  software freeze level; legacy immediate freeze.
- global_pb_mode  in  PB_MODE_W  playback mode applied to unmasked buffers.
- freeze_mask  in  N_SB  bit i = 1 excludes buffer i from any freeze.
- playback_mask  in  N_SB*PB_MODE_W  field i nonzero forces buffer i mode to 0.
- arm  in  1  one-cycle pulse; arms the sequencer.
- trig_in  in  1  one-cycle trigger pulse.
- release  in  1  one-cycle pulse; returns the sequencer to IDLE.
- post_trig_dly  in  DLY_W  cycles between accepted trigger and freeze.
- cnt_clr  in  1  clears trig_cnt.
- freeze  out  N_SB  per-buffer freeze.
- playback_mode  out  N_SB*PB_MODE_W  per-buffer mode; field i at [PB_MODE_W*i +: PB_MODE_W].
- seq_state  out  2  IDLE=0, ARMED=1, DELAY=2, FROZEN=3.
- trig_cnt  out  CNT_W  accepted-trigger count, saturating.

Behaviour:
- Reset (async assert, sync-released use): state IDLE, freeze=0, playback_mode=0, trig_cnt=0, delay counter=0.
- All outputs are registered.
- FSM transitions:
  - IDLE→ARMED on arm.
  - ARMED→DELAY on trig_in when post_trig_dly≠0; counter loads post_trig_dly-1. ARMED→FROZEN on trig_in when post_trig_dly=0.
  - DELAY: decrement each cycle; →FROZEN in the cycle the counter is 0.
  - FROZEN→IDLE on release.
  - release in ARMED or DELAY aborts to IDLE; no freeze occurs.
- Simultaneous events:
  - release beats arm and trig_in in every state.
  - arm in ARMED/DELAY/FROZEN is ignored.
  - trig_in outside ARMED is ignored and not counted.
  - arm and trig_in together in IDLE: go to ARMED only; the trigger is not accepted.
- Trigger latency: trigger accepted at cycle T gives freeze high at T+1+post_trig_dly.
- post_trig_dly is sampled only at trigger acceptance; later changes do not affect a running delay.
- freeze[i] (next) = ~freeze_mask[i] & (global_freeze | next_state==FROZEN). It therefore updates in the same cycle as the state register, and mask changes are visible one cycle later.
- playback_mode field i (next) = (playback_mask field i == 0) ? global_pb_mode : 0.
  - Updated every cycle in IDLE and FROZEN.
  - Held (frozen value) while ARMED or DELAY, so the mode never changes mid-capture.
- Mask field i always comes from bits [PB_MODE_W*i +: PB_MODE_W]. There is no word banking, so all N_SB channels index correctly.
- trig_cnt:
  - Increments by 1 on each accepted trigger.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment and gives 0 next cycle.
- Reset asserted mid-sequence: immediate return to reset values; no pending delay survives.

Decomposition:
- Shared package fm_sb_pkg holds:
  - seq_state_t enum (IDLE, ARMED, DELAY, FROZEN).
  - Default constants for N_SB / PB_MODE_W / DLY_W / CNT_W, matching total_sb and pb_mode_width.
- One natural sub-module, fm_sb_mask_decode: the combinational per-channel freeze/playback mask decode, generate-looped over N_SB.
- The FSM, delay counter and trig_cnt stay in the top.

Test Plan:
- Reset with all inputs driven nonzero → freeze=0, playback_mode=0, seq_state=0, trig_cnt=0; release reset → remains idle.
- arm @T0, trig_in @T5, post_trig_dly=3, freeze_mask=0x0000_0001 → freeze=0xFFFF_FFFE first seen at T9, seq_state=3, trig_cnt=1; release @T12 → freeze=0 at T13.
- post_trig_dly=0, arm then trig_in → freeze asserted the cycle after the trigger; a second trig_in while FROZEN leaves trig_cnt=1.
- global_pb_mode=2, playback_mask field 17=1 (N_SB=32) → channel 17 mode 0, all others 2; change global_pb_mode to 1 during DELAY → outputs hold 2 until FROZEN, then become 1.
- arm @T0, trig_in @T2 with post_trig_dly=10, release @T6 → seq_state=0 at T7, freeze never asserted.
- trig_cnt at 0xFFFF plus an accepted trigger → stays 0xFFFF; cnt_clr together with an accepted trigger → 0.
- global_freeze=1 in IDLE with freeze_mask=0xF → freeze=0xFFFF_FFF0 next cycle; seq_state stays 0.

Source files
------------

// File: rtl/fm_sb_pkg.sv
// fm_sb_pkg: shared sequencer state type and default sizing for the FM spy-buffer freeze controller
package fm_sb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    DELAY  = 2'd2,
    FROZEN = 2'd3
  } seq_state_t;
  localparam int TOTAL_SB      = 32;
  localparam int PB_MODE_WIDTH = 2;
  localparam int DLY_WIDTH     = 16;
  localparam int CNT_WIDTH     = 16;
endpackage

// File: rtl/fm_sb_mask_decode.sv
// fm_sb_mask_decode: per-channel freeze / playback-mode mask decode (in: masks, global freeze/mode, frozen; out: next freeze and mode vectors)
module fm_sb_mask_decode
  import fm_sb_pkg::*;
#(
  parameter int N_SB      = TOTAL_SB,
  parameter int PB_MODE_W = PB_MODE_WIDTH
) (
  input  logic                        global_freeze,
  input  logic                        frozen_i,
  input  logic [N_SB-1:0]             freeze_mask,
  input  logic [PB_MODE_W-1:0]        global_pb_mode,
  input  logic [N_SB*PB_MODE_W-1:0]   playback_mask,
  output logic [N_SB-1:0]             freeze_d,
  output logic [N_SB*PB_MODE_W-1:0]   pb_mode_d
);
  for (genvar i = 0; i < N_SB; i++) begin : g_ch
    assign freeze_d[i] = ~freeze_mask[i] & (global_freeze | frozen_i);
    assign pb_mode_d[PB_MODE_W*i +: PB_MODE_W] =
      (playback_mask[PB_MODE_W*i +: PB_MODE_W] == '0) ? global_pb_mode : '0;
  end
endmodule

// File: rtl/fm_sb_freeze_seq.sv
// fm_sb_freeze_seq: arm/trigger/delay freeze sequencer driving per-buffer freeze and playback mode (in: control pulses, masks; out: freeze, playback_mode, seq_state, trig_cnt)
module fm_sb_freeze_seq
  import fm_sb_pkg::*;
#(
  parameter int N_SB      = TOTAL_SB,
  parameter int PB_MODE_W = PB_MODE_WIDTH,
  parameter int DLY_W     = DLY_WIDTH,
  parameter int CNT_W     = CNT_WIDTH
) (
  input  logic                      axi_clk,
  input  logic                      axi_rst_n,
  input  logic                      global_freeze,
  input  logic [PB_MODE_W-1:0]      global_pb_mode,
  input  logic [N_SB-1:0]           freeze_mask,
  input  logic [N_SB*PB_MODE_W-1:0] playback_mask,
  input  logic                      arm,
  input  logic                      trig_in,
  input  logic                      release_i,
  input  logic [DLY_W-1:0]          post_trig_dly,
  input  logic                      cnt_clr,
  output logic [N_SB-1:0]           freeze,
  output logic [N_SB*PB_MODE_W-1:0] playback_mode,
  output logic [1:0]                seq_state,
  output logic [CNT_W-1:0]          trig_cnt
);
  seq_state_t                state_q, state_d;
  logic [DLY_W-1:0]          dly_q, dly_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [N_SB-1:0]           freeze_q, freeze_d;
  logic [N_SB*PB_MODE_W-1:0] pb_q, pb_d, pb_dec;
  logic                      trig_acc, pb_upd;
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      IDLE:   state_d = arm ? ARMED : IDLE;
      ARMED: if (trig_in) begin
        state_d = (post_trig_dly == '0) ? FROZEN : DELAY;
        dly_d   = (post_trig_dly == '0) ? '0 : post_trig_dly - DLY_W'(1);
      end
      DELAY: begin
        state_d = (dly_q == '0) ? FROZEN : DELAY;
        dly_d   = (dly_q == '0) ? '0 : dly_q - DLY_W'(1);
      end
      default: state_d = FROZEN;
    endcase
    if (release_i) begin
      state_d = IDLE;
      dly_d   = '0;
    end
  end
  assign trig_acc = (state_q == ARMED) && trig_in && !release_i;
  assign cnt_d    = cnt_clr ? '0 : (trig_acc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  // mode is sampled only outside a capture so it cannot change mid-capture
  assign pb_upd   = (state_q == IDLE) || (state_q == FROZEN);
  assign pb_d     = pb_upd ? pb_dec : pb_q;
  fm_sb_mask_decode #(.N_SB(N_SB), .PB_MODE_W(PB_MODE_W)) u_dec (
    .global_freeze (global_freeze),
    .frozen_i      (state_d == FROZEN),
    .freeze_mask   (freeze_mask),
    .global_pb_mode(global_pb_mode),
    .playback_mask (playback_mask),
    .freeze_d      (freeze_d),
    .pb_mode_d     (pb_dec)
  );
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      state_q  <= IDLE;
      dly_q    <= '0;
      cnt_q    <= '0;
      freeze_q <= '0;
      pb_q     <= '0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      freeze_q <= freeze_d;
      pb_q     <= pb_d;
    end
  end
  assign freeze        = freeze_q;
  assign playback_mode = pb_q;
  assign seq_state     = state_q;
  assign trig_cnt      = cnt_q;
endmodule

// File: tb/tb_fm_sb_freeze_seq.sv
// tb_fm_sb_freeze_seq: scoreboard bench for the spy-buffer freeze sequencer
module tb_fm_sb_freeze_seq;
  localparam int N_SB = 32;
  localparam int PB_MODE_W = 2;
  localparam int DLY_W = 16;
  localparam int CNT_W = 8;
  logic              clk = 1'b0;
  logic              rst_n;
  logic              global_freeze;
  logic [1:0]        global_pb_mode;
  logic [31:0]       freeze_mask;
  logic [63:0]       playback_mask;
  logic              arm, trig_in, rel, cnt_clr;
  logic [DLY_W-1:0]  post_trig_dly;
  logic [31:0]       freeze;
  logic [63:0]       playback_mode;
  logic [1:0]        seq_state;
  logic [CNT_W-1:0]  trig_cnt;
  int                total = 0;
  int                bad = 0;
  string             nm_q[$];
  logic [63:0]       exp_q[$];
  string             cur_n;
  logic [63:0]       cur_v;
  fm_sb_freeze_seq #(.N_SB(N_SB), .PB_MODE_W(PB_MODE_W), .DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
    .axi_clk       (clk),
    .axi_rst_n     (rst_n),
    .global_freeze (global_freeze),
    .global_pb_mode(global_pb_mode),
    .freeze_mask   (freeze_mask),
    .playback_mask (playback_mask),
    .arm           (arm),
    .trig_in       (trig_in),
    .release_i     (rel),
    .post_trig_dly (post_trig_dly),
    .cnt_clr       (cnt_clr),
    .freeze        (freeze),
    .playback_mode (playback_mode),
    .seq_state     (seq_state),
    .trig_cnt      (trig_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input string n, input logic [63:0] v);
    nm_q.push_back(n);
    exp_q.push_back(v);
  endtask
  task automatic pop;
    cur_n = nm_q.pop_front();
    cur_v = exp_q.pop_front();
    total++;
  endtask
  task automatic clear_cnt;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    global_freeze = 1'b1; global_pb_mode = 2'b11; freeze_mask = 32'h5A5A_A5A5;
    playback_mask = 64'h1; arm = 1'b1; trig_in = 1'b1; rel = 1'b1;
    post_trig_dly = 16'h7; cnt_clr = 1'b1;
    push("rst_freeze", 64'h0); push("rst_pb", 64'h0); push("rst_state", 64'h0); push("rst_cnt", 64'h0);
    tick(); tick();
    pop(); if (64'(freeze) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, freeze, cur_v); end
    pop(); if (playback_mode !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, playback_mode, cur_v); end
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    pop(); if (64'(trig_cnt) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, trig_cnt, cur_v); end
    global_freeze = 1'b0; global_pb_mode = 2'b00; freeze_mask = '0; playback_mask = '0;
    arm = 1'b0; trig_in = 1'b0; rel = 1'b0; post_trig_dly = '0; cnt_clr = 1'b0;
    tick();
    rst_n = 1'b1;
    push("post_rst_state", 64'h0); push("post_rst_freeze", 64'h0);
    repeat (3) tick();
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    pop(); if (64'(freeze) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, freeze, cur_v); end
  endtask
  task automatic test_delay_freeze;
    freeze_mask = 32'h1; post_trig_dly = 16'd3;
    clear_cnt();
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (4) tick();
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    post_trig_dly = 16'd0;
    push("dly_state_T6", 64'd2);
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    tick(); tick();
    push("dly_freeze_T8", 64'h0);
    pop(); if (64'(freeze) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, freeze, cur_v); end
    tick();
    push("dly_freeze_T9", 64'hFFFF_FFFE); push("dly_state_T9", 64'd3); push("dly_cnt_T9", 64'd1);
    pop(); if (64'(freeze) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, freeze, cur_v); end
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    pop(); if (64'(trig_cnt) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, trig_cnt, cur_v); end
    repeat (3) tick();
    rel = 1'b1; tick(); rel = 1'b0;
    push("rel_freeze_T13", 64'h0); push("rel_state_T13", 64'd0);
    pop(); if (64'(freeze) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, freeze, cur_v); end
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    freeze_mask = '0;
  endtask
  task automatic test_zero_delay;
    post_trig_dly = '0;
    clear_cnt();
    arm = 1'b1; tick(); arm = 1'b0;
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    push("zd_freeze", 64'hFFFF_FFFF); push("zd_state", 64'd3);
    pop(); if (64'(freeze) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, freeze, cur_v); end
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    push("zd_retrig_cnt", 64'd1); push("zd_retrig_state", 64'd3);
    pop(); if (64'(trig_cnt) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, trig_cnt, cur_v); end
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    rel = 1'b1; tick(); rel = 1'b0;
  endtask
  task automatic test_pb_mode;
    logic [63:0] e2, e1;
    for (int i = 0; i < N_SB; i++) begin
      e2[2*i +: 2] = (i == 17) ? 2'd0 : 2'd2;
      e1[2*i +: 2] = (i == 17) ? 2'd0 : 2'd1;
    end
    global_pb_mode = 2'd2; playback_mask = 64'h1 << 34;
    tick();
    push("pb_idle", e2);
    pop(); if (playback_mode !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, playback_mode, cur_v); end
    post_trig_dly = 16'd4;
    arm = 1'b1; tick(); arm = 1'b0;
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    global_pb_mode = 2'd1;
    tick();
    push("pb_delay_hold", e2); push("pb_delay_state", 64'd2);
    pop(); if (playback_mode !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, playback_mode, cur_v); end
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    tick(); tick();
    push("pb_delay_hold_late", e2);
    pop(); if (playback_mode !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, playback_mode, cur_v); end
    tick();
    push("pb_frozen_state", 64'd3);
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    tick();
    push("pb_frozen_update", e1);
    pop(); if (playback_mode !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, playback_mode, cur_v); end
    rel = 1'b1; tick(); rel = 1'b0;
    global_pb_mode = 2'd0; playback_mask = '0;
    tick();
  endtask
  task automatic test_abort;
    logic frz_or;
    frz_or = 1'b0;
    post_trig_dly = 16'd10;
    arm = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      frz_or |= |freeze;
      arm = 1'b0;
      trig_in = (c == 2);
      rel = (c == 6);
      if (c == 7) begin
        push("abort_state_T7", 64'd0);
        pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
      end
    end
    trig_in = 1'b0; rel = 1'b0;
    push("abort_no_freeze", 64'd0);
    pop(); if (64'(frz_or) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, frz_or, cur_v); end
  endtask
  task automatic test_saturation;
    post_trig_dly = '0;
    clear_cnt();
    for (int i = 0; i < 260; i++) begin
      arm = 1'b1; tick(); arm = 1'b0;
      trig_in = 1'b1; tick(); trig_in = 1'b0;
      rel = 1'b1; tick(); rel = 1'b0;
      if (i == 99) begin
        push("cnt_100", 64'd100);
        pop(); if (64'(trig_cnt) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, trig_cnt, cur_v); end
      end
    end
    push("cnt_sat", 64'hFF);
    pop(); if (64'(trig_cnt) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, trig_cnt, cur_v); end
    arm = 1'b1; tick(); arm = 1'b0;
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    push("cnt_sat_hold", 64'hFF);
    pop(); if (64'(trig_cnt) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, trig_cnt, cur_v); end
    rel = 1'b1; tick(); rel = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    trig_in = 1'b1; cnt_clr = 1'b1; tick(); trig_in = 1'b0; cnt_clr = 1'b0;
    push("cnt_clr_prio", 64'h0); push("cnt_clr_state", 64'd3);
    pop(); if (64'(trig_cnt) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, trig_cnt, cur_v); end
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    rel = 1'b1; tick(); rel = 1'b0;
  endtask
  task automatic test_global_freeze;
    freeze_mask = 32'hF; global_freeze = 1'b1;
    tick();
    push("gf_freeze", 64'hFFFF_FFF0); push("gf_state", 64'd0);
    pop(); if (64'(freeze) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, freeze, cur_v); end
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    global_freeze = 1'b0; freeze_mask = '0;
    tick();
    push("gf_off", 64'h0);
    pop(); if (64'(freeze) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, freeze, cur_v); end
  endtask
  task automatic test_simultaneous;
    clear_cnt();
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    push("idle_trig_state", 64'd0); push("idle_trig_cnt", 64'd0);
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    pop(); if (64'(trig_cnt) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, trig_cnt, cur_v); end
    arm = 1'b1; trig_in = 1'b1; tick(); arm = 1'b0; trig_in = 1'b0;
    push("arm_trig_state", 64'd1); push("arm_trig_cnt", 64'd0);
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    pop(); if (64'(trig_cnt) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, trig_cnt, cur_v); end
    arm = 1'b1; trig_in = 1'b1; rel = 1'b1; tick(); arm = 1'b0; trig_in = 1'b0; rel = 1'b0;
    push("rel_prio_state", 64'd0); push("rel_prio_cnt", 64'd0);
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    pop(); if (64'(trig_cnt) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, trig_cnt, cur_v); end
  endtask
  task automatic test_async_reset;
    post_trig_dly = 16'd5;
    arm = 1'b1; tick(); arm = 1'b0;
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    push("arst_state", 64'd0); push("arst_cnt", 64'd0);
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    pop(); if (64'(trig_cnt) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, trig_cnt, cur_v); end
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    push("arst_no_pending_state", 64'd0); push("arst_no_pending_freeze", 64'd0);
    pop(); if (64'(seq_state) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, seq_state, cur_v); end
    pop(); if (64'(freeze) !== cur_v) begin bad++; $display("FAIL %s got=%h exp=%h", cur_n, freeze, cur_v); end
  endtask
  initial begin
    test_reset();
    test_delay_freeze();
    test_zero_delay();
    test_pb_mode();
    test_abort();
    test_saturation();
    test_global_freeze();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
